// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and default widths for the memory read arbiter.
// The feature macro MEM_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_ADDR = 2'b01,
    ARB_DATA = 2'b10
  } arb_state_e;

  localparam int N_MASTERS_DEF  = 3;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 4;
  localparam int ID_WIDTH_DEF   = 4;

  // Round-robin successor of a grant index, wrapping N-1 back to 0.
  function automatic int unsigned ptr_after(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Master-side request/response bus plus memory read port of the arbiter.
// slave modport is the arbiter's view; master modport is the environment's view.
interface mem_read_arbiter_if #(
  parameter int N_MASTERS  = mem_arb_pkg::N_MASTERS_DEF,
  parameter int ADDR_WIDTH = mem_arb_pkg::ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = mem_arb_pkg::DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = mem_arb_pkg::LEN_WIDTH_DEF,
  parameter int ID_WIDTH   = mem_arb_pkg::ID_WIDTH_DEF
);

  logic [N_MASTERS*ADDR_WIDTH-1:0] m_araddr;
  logic [N_MASTERS*LEN_WIDTH-1:0]  m_arlen;
  logic [N_MASTERS*ID_WIDTH-1:0]   m_arid;
  logic [N_MASTERS-1:0]            m_arvalid;
  logic [N_MASTERS-1:0]            m_arready;
  logic [N_MASTERS-1:0]            m_rvalid;
  logic [DATA_WIDTH-1:0]           m_rdata;
  logic [ADDR_WIDTH-1:0]           s_araddr;
  logic [LEN_WIDTH-1:0]            s_arlen;
  logic [ID_WIDTH-1:0]             s_arid;
  logic                            s_arvalid;
  logic                            s_arready;
  logic                            s_rvalid;
  logic [DATA_WIDTH-1:0]           s_rdata;
  logic                            s_rready;

  modport slave (
    input  m_araddr, m_arlen, m_arid, m_arvalid, s_arready, s_rvalid, s_rdata,
    output m_arready, m_rvalid, m_rdata, s_araddr, s_arlen, s_arid, s_arvalid, s_rready
  );

  modport master (
    output m_araddr, m_arlen, m_arid, m_arvalid, s_arready, s_rvalid, s_rdata,
    input  m_arready, m_rvalid, m_rdata, s_araddr, s_arlen, s_arid, s_arvalid, s_rready
  );

endinterface

// File: rtl/mem_read_arbiter_rr_arbiter.sv
// Combinational N-way arbiter: request vector + start pointer -> one-hot grant and index.
// With MEM_ARB_FIXED_PRIO_EN defined the lowest index always wins and the pointer is ignored.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_start,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  // Scan indices starting at the pointer; the first requester found wins.
  always_comb begin
    int   v_idx;
    logic v_found;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    v_found = 1'b0;
    v_idx   = 0;
    for (int k = 0; k < N; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      v_idx = k;
`else
      v_idx = (int'(i_start) + k) % N;
`endif
      if (!v_found && i_req[v_idx]) begin
        v_found      = 1'b1;
        o_gnt[v_idx] = 1'b1;
        o_idx        = PW'(v_idx);
      end else begin
        v_found = v_found;
      end
    end
    o_valid = v_found;
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Single-outstanding read arbiter: grants one master burst at a time, forwards its
// AR beat to memory and steers the returning R beats to that master only.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_MASTERS  = N_MASTERS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_read_arbiter_if.slave  bus
);

  localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [PW-1:0]         r_grant_idx;
  logic [PW-1:0]         r_rr_ptr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [ID_WIDTH-1:0]   r_id;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;

  logic [N_MASTERS-1:0]  w_gnt_oh;
  logic [PW-1:0]         w_gnt_idx;
  logic                  w_gnt_valid;
  logic                  w_load;
  logic                  w_addr_fire;
  logic                  w_beat_fire;
  logic                  w_burst_done;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [LEN_WIDTH-1:0]  w_sel_len;
  logic [ID_WIDTH-1:0]   w_sel_id;

  rr_arbiter #(.N(N_MASTERS), .PW(PW)) u_rr_arbiter (
    .i_req   (bus.m_arvalid),
    .i_start (r_rr_ptr),
    .o_gnt   (w_gnt_oh),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid)
  );

  // Pick the winning master's request fields out of the packed request buses.
  always_comb begin
    w_sel_addr = bus.m_araddr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_sel_len  = bus.m_arlen[int'(w_gnt_idx)*LEN_WIDTH +: LEN_WIDTH];
    w_sel_id   = bus.m_arid[int'(w_gnt_idx)*ID_WIDTH +: ID_WIDTH];
  end

  // FSM state register; reset drops any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and bus outputs; every output is zero outside its own phase.
  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_addr_fire    = 1'b0;
    w_beat_fire    = 1'b0;
    w_burst_done   = 1'b0;
    bus.m_arready  = '0;
    bus.m_rvalid   = '0;
    bus.m_rdata    = '0;
    bus.s_araddr   = '0;
    bus.s_arlen    = '0;
    bus.s_arid     = '0;
    bus.s_arvalid  = 1'b0;
    bus.s_rready   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_gnt_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ARB_ADDR;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_ADDR: begin
        bus.s_arvalid              = 1'b1;
        bus.s_araddr               = r_addr;
        bus.s_arlen                = r_len;
        bus.s_arid                 = r_id;
        bus.m_arready[r_grant_idx] = bus.s_arready;
        if (bus.s_arready) begin
          w_addr_fire = 1'b1;
          w_state_nxt = ARB_DATA;
        end else begin
          w_state_nxt = ARB_ADDR;
        end
      end
      ARB_DATA: begin
        bus.s_rready              = 1'b1;
        bus.m_rdata               = bus.s_rdata;
        bus.m_rvalid[r_grant_idx] = bus.s_rvalid;
        w_beat_fire               = bus.s_rvalid;
        if (bus.s_rvalid && (r_beat_cnt == (r_len - LEN_WIDTH'(1)))) begin
          w_burst_done = 1'b1;
          w_state_nxt  = ARB_IDLE;
        end else begin
          w_state_nxt = ARB_DATA;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Latch the granted request, count beats and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_id        <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (w_load) begin
        r_grant_idx <= w_gnt_idx;
        r_addr      <= w_sel_addr;
        r_len       <= (w_sel_len == '0) ? LEN_WIDTH'(1) : w_sel_len;
        r_id        <= w_sel_id;
      end
      if (w_addr_fire) begin
        r_beat_cnt <= '0;
      end else if (w_beat_fire) begin
        r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
      end
      if (w_burst_done) begin
        r_rr_ptr <= PW'(ptr_after(32'(r_grant_idx), 32'(N_MASTERS)));
      end
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed self-checking bench for mem_read_arbiter.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_mem_read_arbiter;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 4;
  localparam int IDW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_read_arbiter_if #(
    .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IDW)
  ) bus ();

  mem_read_arbiter #(
    .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IDW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic set_master(input int i, input logic [AW-1:0] a,
                            input logic [LW-1:0] l, input logic [IDW-1:0] id);
    bus.m_araddr[i*AW +: AW] = a;
    bus.m_arlen[i*LW +: LW]  = l;
    bus.m_arid[i*IDW +: IDW] = id;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.s_arvalid !== 1'b0) begin errors++; $display("FAIL rst_s_arvalid got=%0b exp=0", bus.s_arvalid); end
    checks++; if (bus.s_rready !== 1'b0) begin errors++; $display("FAIL rst_s_rready got=%0b exp=0", bus.s_rready); end
    checks++; if (bus.m_arready !== 3'b000) begin errors++; $display("FAIL rst_m_arready got=%b exp=000", bus.m_arready); end
    checks++; if (bus.m_rvalid !== 3'b000) begin errors++; $display("FAIL rst_m_rvalid got=%b exp=000", bus.m_rvalid); end
    checks++; if (bus.s_araddr !== 32'h0) begin errors++; $display("FAIL rst_s_araddr got=%h exp=0", bus.s_araddr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.s_arvalid !== 1'b0) begin errors++; $display("FAIL rst_idle_arvalid got=%0b exp=0", bus.s_arvalid); end
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    set_master(1, 32'h0000_0100, 4'd4, 4'd5);
    bus.m_arvalid = 3'b010;
    #1;
    checks++; if (bus.s_arvalid !== 1'b0) begin errors++; $display("FAIL t1_idle_arvalid got=%0b exp=0", bus.s_arvalid); end
    @(negedge clk);
    #1;
    checks++; if (bus.s_arvalid !== 1'b1) begin errors++; $display("FAIL t1_arvalid got=%0b exp=1", bus.s_arvalid); end
    checks++; if (bus.s_araddr !== 32'h0000_0100) begin errors++; $display("FAIL t1_araddr got=%h exp=00000100", bus.s_araddr); end
    checks++; if (bus.s_arlen !== 4'd4) begin errors++; $display("FAIL t1_arlen got=%0d exp=4", bus.s_arlen); end
    checks++; if (bus.s_arid !== 4'd5) begin errors++; $display("FAIL t1_arid got=%0d exp=5", bus.s_arid); end
    checks++; if (bus.m_arready !== 3'b000) begin errors++; $display("FAIL t1_arready_pre got=%b exp=000", bus.m_arready); end
    bus.s_arready = 1'b1;
    bus.m_arvalid = 3'b000;
    #1;
    checks++; if (bus.m_arready !== 3'b010) begin errors++; $display("FAIL t1_arready got=%b exp=010", bus.m_arready); end
    @(negedge clk);
    bus.s_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = 32'hD000_0000 + 32'(b);
      #1;
      checks++; if (bus.m_rvalid !== 3'b010) begin errors++; $display("FAIL t1_rvalid beat%0d got=%b exp=010", b, bus.m_rvalid); end
      checks++; if (bus.m_rdata !== 32'hD000_0000 + 32'(b)) begin errors++; $display("FAIL t1_rdata beat%0d got=%h exp=%h", b, bus.m_rdata, 32'hD000_0000 + 32'(b)); end
      checks++; if (bus.s_rready !== 1'b1) begin errors++; $display("FAIL t1_rready beat%0d got=%0b exp=1", b, bus.s_rready); end
      @(negedge clk);
    end
    bus.s_rvalid = 1'b0;
    #1;
    checks++; if (bus.s_rready !== 1'b0) begin errors++; $display("FAIL t1_end_rready got=%0b exp=0", bus.s_rready); end
    checks++; if (bus.s_arvalid !== 1'b0) begin errors++; $display("FAIL t1_end_arvalid got=%0b exp=0", bus.s_arvalid); end
  endtask

  task automatic test_round_robin();
    int         exp_order [4];
    logic [2:0] exp_oh;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0};
`endif
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_master(i, 32'h0000_1000 + 32'(i) * 32'h10, 4'd1, 4'(i + 8));
    end
    bus.m_arvalid = 3'b111;
    for (int g = 0; g < 4; g++) begin
      exp_oh = 3'b001 << exp_order[g];
      bus.s_rvalid = 1'b0;
      #1;
      checks++; if (bus.s_arvalid !== 1'b0) begin errors++; $display("FAIL t2_idle_arvalid g%0d got=%0b exp=0", g, bus.s_arvalid); end
      @(negedge clk);
      #1;
      checks++; if (bus.s_araddr !== 32'h0000_1000 + 32'(exp_order[g]) * 32'h10) begin errors++; $display("FAIL t2_araddr g%0d got=%h exp=%h", g, bus.s_araddr, 32'h0000_1000 + 32'(exp_order[g]) * 32'h10); end
      checks++; if (bus.s_arid !== 4'(exp_order[g] + 8)) begin errors++; $display("FAIL t2_arid g%0d got=%0d exp=%0d", g, bus.s_arid, exp_order[g] + 8); end
      bus.s_arready = 1'b1;
      #1;
      checks++; if (bus.m_arready !== exp_oh) begin errors++; $display("FAIL t2_arready g%0d got=%b exp=%b", g, bus.m_arready, exp_oh); end
      @(negedge clk);
      bus.s_arready = 1'b0;
      bus.s_rvalid  = 1'b1;
      bus.s_rdata   = 32'hA5A5_0000 + 32'(g);
      #1;
      checks++; if (bus.m_rvalid !== exp_oh) begin errors++; $display("FAIL t2_rvalid g%0d got=%b exp=%b", g, bus.m_rvalid, exp_oh); end
      @(negedge clk);
    end
    bus.s_rvalid  = 1'b0;
    bus.m_arvalid = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_ar_stall();
    set_master(0, 32'h0000_0200, 4'd2, 4'd3);
    bus.m_arvalid = 3'b001;
    @(negedge clk);
    bus.m_arvalid = 3'b000;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.s_arvalid !== 1'b1) begin errors++; $display("FAIL t3_arvalid c%0d got=%0b exp=1", c, bus.s_arvalid); end
      checks++; if (bus.s_araddr !== 32'h0000_0200 || bus.s_arlen !== 4'd2 || bus.s_arid !== 4'd3) begin
        errors++; $display("FAIL t3_fields c%0d got=%h/%0d/%0d exp=00000200/2/3", c, bus.s_araddr, bus.s_arlen, bus.s_arid);
      end
      checks++; if (bus.m_arready !== 3'b000) begin errors++; $display("FAIL t3_arready c%0d got=%b exp=000", c, bus.m_arready); end
      @(negedge clk);
    end
    bus.s_arready = 1'b1;
    #1;
    checks++; if (bus.m_arready !== 3'b001) begin errors++; $display("FAIL t3_arready_acc got=%b exp=001", bus.m_arready); end
    @(negedge clk);
    bus.s_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = 32'h3300_0000 + 32'(b);
      #1;
      checks++; if (bus.m_rvalid !== 3'b001) begin errors++; $display("FAIL t3_rvalid beat%0d got=%b exp=001", b, bus.m_rvalid); end
      @(negedge clk);
    end
    bus.s_rvalid = 1'b0;
    #1;
    checks++; if (bus.s_rready !== 1'b0) begin errors++; $display("FAIL t3_end_rready got=%0b exp=0", bus.s_rready); end
  endtask

  task automatic test_len_zero();
    set_master(2, 32'h0000_0300, 4'd0, 4'hA);
    bus.m_arvalid = 3'b100;
    @(negedge clk);
    #1;
    checks++; if (bus.s_arlen !== 4'd1) begin errors++; $display("FAIL t4_arlen got=%0d exp=1", bus.s_arlen); end
    bus.s_arready = 1'b1;
    bus.m_arvalid = 3'b000;
    @(negedge clk);
    bus.s_arready = 1'b0;
    bus.s_rvalid  = 1'b1;
    bus.s_rdata   = 32'h0000_BEEF;
    #1;
    checks++; if (bus.m_rvalid !== 3'b100) begin errors++; $display("FAIL t4_rvalid got=%b exp=100", bus.m_rvalid); end
    @(negedge clk);
    #1;
    checks++; if (bus.m_rvalid !== 3'b000) begin errors++; $display("FAIL t4_extra_rvalid got=%b exp=000", bus.m_rvalid); end
    checks++; if (bus.s_rready !== 1'b0) begin errors++; $display("FAIL t4_idle_rready got=%0b exp=0", bus.s_rready); end
    bus.s_rvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    set_master(0, 32'h0000_0400, 4'd4, 4'd1);
    bus.m_arvalid = 3'b001;
    @(negedge clk);
    bus.s_arready = 1'b1;
    bus.m_arvalid = 3'b000;
    @(negedge clk);
    bus.s_arready = 1'b0;
    bus.s_rvalid  = 1'b1;
    bus.s_rdata   = 32'h5500_0001;
    @(negedge clk);
    bus.s_rdata = 32'h5500_0002;
    #1;
    checks++; if (bus.m_rvalid !== 3'b001) begin errors++; $display("FAIL t5_beat2_rvalid got=%b exp=001", bus.m_rvalid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.m_rvalid !== 3'b000 || bus.s_rready !== 1'b0) begin
      errors++; $display("FAIL t5_rst_r got=%b/%0b exp=000/0", bus.m_rvalid, bus.s_rready);
    end
    checks++; if (bus.s_arvalid !== 1'b0 || bus.m_arready !== 3'b000) begin
      errors++; $display("FAIL t5_rst_ar got=%0b/%b exp=0/000", bus.s_arvalid, bus.m_arready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (bus.m_rvalid !== 3'b000) begin errors++; $display("FAIL t5_stale_rvalid c%0d got=%b exp=000", c, bus.m_rvalid); end
      checks++; if (bus.s_rready !== 1'b0) begin errors++; $display("FAIL t5_stale_rready c%0d got=%0b exp=0", c, bus.s_rready); end
      @(negedge clk);
    end
    bus.s_rvalid = 1'b0;
  endtask

  task automatic test_idle_rvalid();
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = 32'h6666_6666;
    #1;
    checks++; if (bus.m_rvalid !== 3'b000) begin errors++; $display("FAIL t6_rvalid got=%b exp=000", bus.m_rvalid); end
    checks++; if (bus.s_rready !== 1'b0) begin errors++; $display("FAIL t6_rready got=%0b exp=0", bus.s_rready); end
    @(negedge clk);
    bus.s_rvalid = 1'b0;
    #1;
    checks++; if (bus.s_arvalid !== 1'b0 || bus.s_rready !== 1'b0) begin
      errors++; $display("FAIL t6_still_idle got=%0b/%0b exp=0/0", bus.s_arvalid, bus.s_rready);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.m_araddr  = '0;
    bus.m_arlen   = '0;
    bus.m_arid    = '0;
    bus.m_arvalid = '0;
    bus.s_arready = 1'b0;
    bus.s_rvalid  = 1'b0;
    bus.s_rdata   = '0;
    rst_n         = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_burst();
    test_round_robin();
    test_ar_stall();
    test_len_zero();
    test_reset_mid_burst();
    test_idle_rvalid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
